// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NRD bypassed read ports,
// optional hardwired-zero register 0 and a per-register busy scoreboard.
module regfile_mp #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2,
    parameter int ZERO0 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_addr,
    output logic              collision,
    output logic [AW:0]       busy_cnt
);
    localparam int DEPTH = 2**AW;

    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic             r_collision;
    logic [AW:0]      r_busy_cnt;

    logic             w_we0;
    logic             w_we1;
    logic             w_iss;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;

    // With ZERO0 set, anything aimed at register 0 is discarded before it
    // reaches storage, bypass, collision detection or the scoreboard.
    assign w_we0 = we0 && !((ZERO0 != 0) && (wa0 == '0));
    assign w_we1 = we1 && !((ZERO0 != 0) && (wa1 == '0));
    assign w_iss = iss_valid && !((ZERO0 != 0) && (iss_addr == '0));

    // Issue is applied after the write-clear so a new producer keeps the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        w_cnt_nxt  = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if ((w_we0 && (wa0 == AW'(a))) || (w_we1 && (wa1 == AW'(a))))
                w_busy_nxt[a] = 1'b0;
            if (w_iss && (iss_addr == AW'(a)))
                w_busy_nxt[a] = 1'b1;
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[a]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++)
                r_mem[a] <= '0;
            r_busy      <= '0;
            r_collision <= 1'b0;
            r_busy_cnt  <= '0;
        end else begin
            if (w_we0)
                r_mem[wa0] <= wd0;
            if (w_we1)
                r_mem[wa1] <= wd1;
            r_busy      <= w_busy_nxt;
            r_collision <= w_we0 && w_we1 && (wa0 == wa1);
            r_busy_cnt  <= w_cnt_nxt;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0] w_ra;
            logic          w_hit0;
            logic          w_hit1;

            assign w_ra   = rd_addr[k*AW +: AW];
            assign w_hit0 = w_we0 && (wa0 == w_ra);
            assign w_hit1 = w_we1 && (wa1 == w_ra);

            // Port 1 bypass outranks port 0, matching the write priority.
            assign rd_data[k*DW +: DW] = w_hit1 ? wd1 :
                                         w_hit0 ? wd0 :
                                         ((ZERO0 != 0) && (w_ra == '0)) ? '0 :
                                         r_mem[w_ra];
            assign rd_busy[k] = r_busy[w_ra] && !(w_hit0 || w_hit1);
        end
    endgenerate

    assign collision = r_collision;
    assign busy_cnt  = r_busy_cnt;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 2-port instance plus a 4-port,
// 64-bit, 64-entry instance with ZERO0=0 exercised against a reference array.
module tb_regfile_mp;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    // Default instance: DW=32 AW=5 NRD=2 ZERO0=1
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we0, we1, iss_valid;
    logic [4:0]  wa0, wa1, iss_addr;
    logic [31:0] wd0, wd1;
    logic        collision;
    logic [5:0]  busy_cnt;

    regfile_mp u_dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .collision(collision), .busy_cnt(busy_cnt)
    );

    // Wide instance: DW=64 AW=6 NRD=4 ZERO0=0
    logic [23:0]  rd_addr4;
    logic [255:0] rd_data4;
    logic [3:0]   rd_busy4;
    logic         we0_4, we1_4, iss_valid4;
    logic [5:0]   wa0_4, wa1_4, iss_addr4;
    logic [63:0]  wd0_4, wd1_4;
    logic         collision4;
    logic [6:0]   busy_cnt4;

    regfile_mp #(.DW(64), .AW(6), .NRD(4), .ZERO0(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr4), .rd_data(rd_data4), .rd_busy(rd_busy4),
        .we0(we0_4), .wa0(wa0_4), .wd0(wd0_4),
        .we1(we1_4), .wa1(wa1_4), .wd1(wd1_4),
        .iss_valid(iss_valid4), .iss_addr(iss_addr4),
        .collision(collision4), .busy_cnt(busy_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
    endtask

    logic [63:0] model [64];
    logic [5:0]  ra [4];
    logic [63:0] exp_rd;
    logic        exp_col;

    initial begin
        rst_n = 1'b0;
        rd_addr = '0; idle(); wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_addr = '0;
        rd_addr4 = '0; we0_4 = 1'b0; we1_4 = 1'b0; iss_valid4 = 1'b0;
        wa0_4 = '0; wa1_4 = '0; wd0_4 = '0; wd1_4 = '0; iss_addr4 = '0;
        #12;
        check("reset_cnt", busy_cnt, 0);
        check("reset_col", collision, 0);
        rst_n = 1'b1;
        tick();

        // Write then read back through bypass and storage
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1234; rd_addr = {5'd0, 5'd3};
        #1;
        check("bypass_wr0", rd_data[31:0], 32'h1234);
        check("bypass_notbusy", rd_busy[0], 0);
        tick(); idle();
        #1;
        check("stored_r3", rd_data[31:0], 32'h1234);

        // Same-address collision, port 1 wins
        we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'hAAAA; wd1 = 32'h5555;
        rd_addr = {5'd7, 5'd3};
        #1;
        check("bypass_prio", rd_data[63:32], 32'h5555);
        check("col_before", collision, 0);
        tick(); idle();
        #1;
        check("col_pulse", collision, 1);
        check("stored_r7", rd_data[63:32], 32'h5555);
        tick();
        check("col_clear", collision, 0);

        // Distinct-address dual write, each port bypasses independently
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA; we1 = 1'b1; wa1 = 5'd10; wd1 = 32'hB;
        rd_addr = {5'd10, 5'd9};
        #1;
        check("dual_p0", rd_data[31:0], 32'hA);
        check("dual_p1", rd_data[63:32], 32'hB);
        tick(); idle();
        check("dual_nocol", collision, 0);

        // Register 0 stays zero and never collides
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1; we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
        rd_addr = {5'd0, 5'd0};
        #1;
        check("zero_bypass", rd_data[31:0], 0);
        tick(); idle();
        #1;
        check("zero_stored", rd_data[63:32], 0);
        check("zero_nocol", collision, 0);
        iss_valid = 1'b1; iss_addr = 5'd0;
        tick(); idle();
        check("zero_notbusy", busy_cnt, 0);

        // Scoreboard
        iss_valid = 1'b1; iss_addr = 5'd5; rd_addr = {5'd0, 5'd5};
        tick(); idle();
        #1;
        check("sb_busy", rd_busy[0], 1);
        check("sb_cnt1", busy_cnt, 1);
        iss_valid = 1'b1; iss_addr = 5'd5; we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h55;
        #1;
        check("sb_mask_wr0", rd_busy[0], 0);
        tick(); idle();
        #1;
        check("sb_newprod", rd_busy[0], 1);
        check("sb_cnt_keep", busy_cnt, 1);
        check("sb_data55", rd_data[31:0], 32'h55);
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h66;
        #1;
        check("sb_mask_wr1", rd_busy[0], 0);
        check("sb_bypass66", rd_data[31:0], 32'h66);
        tick(); idle();
        #1;
        check("sb_cnt0", busy_cnt, 0);
        check("sb_clear", rd_busy[0], 0);
        iss_valid = 1'b1; iss_addr = 5'd1; tick();
        tick();
        check("sb_waw", busy_cnt, 1);
        iss_addr = 5'd2; tick(); idle();
        check("sb_cnt2", busy_cnt, 2);

        // Mid-run reset with a collision pending and a write held across an edge
        we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'h1; wd1 = 32'h2;
        tick(); idle();
        check("pre_rst_col", collision, 1);
        rd_addr = {5'd7, 5'd3};
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_r3", rd_data[31:0], 0);
        check("rst_r7", rd_data[63:32], 0);
        check("rst_cnt", busy_cnt, 0);
        check("rst_col", collision, 0);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEAD;
        tick(); idle();
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_lost_wr", rd_data[31:0], 0);
        tick();

        // Wide instance: random traffic against a reference array
        for (int i = 0; i < 64; i++) model[i] = '0;
        for (int it = 0; it < 60; it++) begin
            we0_4 = 1'($urandom_range(0, 1)); wa0_4 = 6'($urandom_range(0, 7));
            we1_4 = 1'($urandom_range(0, 1)); wa1_4 = 6'($urandom_range(0, 7));
            if (it % 10 == 0) wa1_4 = 6'd63;
            wd0_4 = {$urandom, $urandom}; wd1_4 = {$urandom, $urandom};
            for (int k = 0; k < 4; k++) begin
                ra[k] = 6'($urandom_range(0, 7));
                if (it % 7 == k) ra[k] = 6'd63;
            end
            rd_addr4 = {ra[3], ra[2], ra[1], ra[0]};
            #1;
            for (int k = 0; k < 4; k++) begin
                if (we1_4 && wa1_4 == ra[k]) exp_rd = wd1_4;
                else if (we0_4 && wa0_4 == ra[k]) exp_rd = wd0_4;
                else exp_rd = model[ra[k]];
                check("wide_rd", rd_data4[k*64 +: 64], exp_rd);
            end
            exp_col = we0_4 && we1_4 && (wa0_4 == wa1_4);
            if (we0_4) model[wa0_4] = wd0_4;
            if (we1_4) model[wa1_4] = wd1_4;
            tick();
            check("wide_col", collision4, 64'(exp_col));
        end
        we0_4 = 1'b0; we1_4 = 1'b0;
        check("wide_cnt", busy_cnt4, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
